mxv_sequencer: RTL and testbench

Parametrised control sequencer for an N×N matrix by N-vector multiply, executed on LANES parallel multiply-accumulate processor lanes.
- Rows are processed in ceil(N/LANES) passes; each pass steps through N columns.
- After each pass, lane results are pushed one per cycle into the result FIFO.
- After the last pass, results are drained to the serial transmitter over a valid/ready handshake.
- Sits between the operand FIFO, the processor array, the result FIFO and the UART TX path.
- Adds over the previous controller: runtime N range check, operand-empty and result-full stalling, multi-lane passes, TX backpressure, busy/done/err status.

---
 rtl/mxv_pkg.sv | 35 +++
 rtl/mxv_index_ctr.sv | 31 +++
 rtl/mxv_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_mxv_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mxv_pkg.sv
// Shared types, default sizing and the lane-mask helper for the mxv sequencer.
package mxv_pkg;

    localparam int MAX_N_DEF = 8;
    localparam int LANES_DEF = 4;
    localparam int NW_DEF    = $clog2(MAX_N_DEF + 1);
    localparam int LW_DEF    = (LANES_DEF > 1) ? $clog2(LANES_DEF) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ERR     = 3'd1,
        LOAD    = 3'd2,
        OP      = 3'd3,
        RESULT  = 3'd4,
        TX_POP  = 3'd5,
        TX_SEND = 3'd6,
        DONE    = 3'd7
    } state_t;

    typedef logic [NW_DEF-1:0] cnt_t;
    typedef logic [LW_DEF-1:0] lane_idx_t;

    // Bit i is set when lane i maps onto a real row (row_base + i < n_q).
    // Returned 32 bits wide so any instance can truncate to its own LANES.
    function automatic logic [31:0] lane_mask(input int unsigned n_q,
                                              input int unsigned row_base);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 32; i++) begin
            m[i] = ((row_base + 32'(i)) < n_q);
        end
        return m;
    endfunction

endpackage

// File: rtl/mxv_index_ctr.sv
// Bounded up-counter: synchronous clear, enable, wraps to zero after the
// terminal value 'limit'; tc flags cnt == limit.
module mxv_index_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_r;

    assign cnt = cnt_r;
    assign tc  = (cnt_r == limit);

    // count register: clear wins over enable, wrap at the terminal value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (en) begin
            cnt_r <= tc ? {W{1'b0}} : (cnt_r + W'(1'b1));
        end
    end

endmodule

// File: rtl/mxv_sequencer.sv
// Control sequencer for an N x N matrix by N-vector multiply on LANES parallel
// MAC lanes; results are collected per pass and drained to the UART TX path.
module mxv_sequencer
    import mxv_pkg::*;
#(
    parameter int MAX_N = MAX_N_DEF,
    parameter int LANES = LANES_DEF,
    parameter int NW    = $clog2(MAX_N + 1),
    parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NW-1:0]    n,
    input  logic             op_empty,
    output logic             op_pop,
    output logic [LANES-1:0] lane_en,
    output logic             acc_clr,
    output logic [NW-1:0]    row_base,
    input  logic             res_full,
    output logic             res_push,
    output logic [LW-1:0]    res_lane,
    output logic             res_pop,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t state_r;
    state_t state_nxt_s;

    logic [NW-1:0] n_q_r;
    logic          n_cap_s;
    logic          n_ok_s;
    logic [NW-1:0] n_last_s;

    logic [NW-1:0] col_cnt_s;
    logic          col_tc_s;
    logic          col_clr_s;
    logic          col_inc_s;

    logic [LW-1:0] lane_cnt_s;
    logic          lane_tc_s;
    logic          lane_clr_s;
    logic          lane_inc_s;
    logic [LW-1:0] lane_last_s;

    logic [NW-1:0] pass_cnt_s;
    logic          pass_tc_s;
    logic          pass_clr_s;
    logic          pass_inc_s;
    logic [NW-1:0] pass_last_s;

    logic [NW-1:0] tx_cnt_s;
    logic          tx_tc_s;
    logic          tx_clr_s;
    logic          tx_inc_s;
    logic          tx_last_s;

    logic [NW-1:0]    row_base_s;
    logic [31:0]      rem_s;
    logic [NW-1:0]    active_s;
    logic [LANES-1:0] lane_mask_s;

    assign n_ok_s   = (n != {NW{1'b0}}) && (32'(n) <= 32'(MAX_N));
    assign n_last_s = n_q_r - NW'(1'b1);

    // Per-pass geometry: first row, number of live lanes and their mask.
    assign row_base_s  = NW'(32'(pass_cnt_s) * 32'(LANES));
    assign rem_s       = 32'(n_q_r) - 32'(row_base_s);
    assign active_s    = (rem_s < 32'(LANES)) ? NW'(rem_s) : NW'(LANES);
    assign lane_last_s = LW'(active_s - NW'(1'b1));
    assign lane_mask_s = LANES'(lane_mask(32'(n_q_r), 32'(row_base_s)));

    // Last pass index is floor((n_q-1)/LANES), i.e. row_base+LANES >= n_q.
    assign pass_last_s = NW'((32'(n_q_r) - 32'd1) / 32'(LANES));

    // Never send more words than the captured length, even on a corrupted count.
    assign tx_last_s = tx_tc_s || (tx_cnt_s > n_last_s);

    assign row_base = row_base_s;
    assign res_lane = lane_cnt_s;
    assign busy     = (state_r != IDLE);

    mxv_index_ctr #(.W(NW)) u_col_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (col_clr_s),
        .en    (col_inc_s),
        .limit (n_last_s),
        .cnt   (col_cnt_s),
        .tc    (col_tc_s)
    );

    mxv_index_ctr #(.W(LW)) u_lane_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (lane_clr_s),
        .en    (lane_inc_s),
        .limit (lane_last_s),
        .cnt   (lane_cnt_s),
        .tc    (lane_tc_s)
    );

    mxv_index_ctr #(.W(NW)) u_pass_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (pass_clr_s),
        .en    (pass_inc_s),
        .limit (pass_last_s),
        .cnt   (pass_cnt_s),
        .tc    (pass_tc_s)
    );

    mxv_index_ctr #(.W(NW)) u_tx_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (tx_clr_s),
        .en    (tx_inc_s),
        .limit (n_last_s),
        .cnt   (tx_cnt_s),
        .tc    (tx_tc_s)
    );

    // job length is captured on any start seen in IDLE, valid or not
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q_r <= {NW{1'b0}};
        end else if (n_cap_s) begin
            n_q_r <= n;
        end
    end

    // sequencer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next-state, counter control and output decode
    always_comb begin
        state_nxt_s = state_r;
        n_cap_s     = 1'b0;
        col_clr_s   = 1'b0;
        col_inc_s   = 1'b0;
        lane_clr_s  = 1'b0;
        lane_inc_s  = 1'b0;
        pass_clr_s  = 1'b0;
        pass_inc_s  = 1'b0;
        tx_clr_s    = 1'b0;
        tx_inc_s    = 1'b0;
        op_pop      = 1'b0;
        lane_en     = {LANES{1'b0}};
        acc_clr     = 1'b0;
        res_push    = 1'b0;
        res_pop     = 1'b0;
        tx_valid    = 1'b0;
        done        = 1'b0;
        err         = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    n_cap_s = 1'b1;
                    if (n_ok_s) begin
                        col_clr_s   = 1'b1;
                        lane_clr_s  = 1'b1;
                        pass_clr_s  = 1'b1;
                        tx_clr_s    = 1'b1;
                        state_nxt_s = LOAD;
                    end else begin
                        state_nxt_s = ERR;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ERR: begin
                err         = 1'b1;
                state_nxt_s = IDLE;
            end
            LOAD: begin
                if (op_empty) begin
                    state_nxt_s = LOAD;
                end else begin
                    op_pop      = 1'b1;
                    state_nxt_s = OP;
                end
            end
            OP: begin
                lane_en   = lane_mask_s;
                acc_clr   = (col_cnt_s == {NW{1'b0}});
                col_inc_s = 1'b1;
                if (col_tc_s) begin
                    lane_clr_s  = 1'b1;
                    state_nxt_s = RESULT;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            RESULT: begin
                if (res_full) begin
                    state_nxt_s = RESULT;
                end else begin
                    res_push   = 1'b1;
                    lane_inc_s = 1'b1;
                    if (!lane_tc_s) begin
                        state_nxt_s = RESULT;
                    end else if (pass_tc_s) begin
                        tx_clr_s    = 1'b1;
                        state_nxt_s = TX_POP;
                    end else begin
                        pass_inc_s  = 1'b1;
                        state_nxt_s = LOAD;
                    end
                end
            end
            TX_POP: begin
                res_pop     = 1'b1;
                state_nxt_s = TX_SEND;
            end
            TX_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    tx_inc_s    = 1'b1;
                    state_nxt_s = tx_last_s ? DONE : TX_POP;
                end else begin
                    state_nxt_s = TX_SEND;
                end
            end
            DONE: begin
                done        = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mxv_sequencer.sv
// Scoreboard bench for mxv_sequencer: a reference job model queues the expected
// strobe sequence (with cycle stamps for done/err) and the monitor pops it.
module tb_mxv_sequencer;
    import mxv_pkg::*;

    localparam int LANES  = LANES_DEF;
    localparam int K_POP  = 1;
    localparam int K_OP   = 2;
    localparam int K_PUSH = 3;
    localparam int K_RPOP = 4;
    localparam int K_TX   = 5;
    localparam int K_DONE = 6;
    localparam int K_ERR  = 7;

    typedef struct {
        int kind;
        int data;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    cnt_t             n = '0;
    logic             op_empty = 1'b0;
    logic             op_pop;
    logic [LANES-1:0] lane_en;
    logic             acc_clr;
    cnt_t             row_base;
    logic             res_full = 1'b0;
    logic             res_push;
    lane_idx_t        res_lane;
    logic             res_pop;
    logic             tx_valid;
    logic             tx_ready = 1'b1;
    logic             busy;
    logic             done;
    logic             err;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  ncyc = 0;
    int  pops_seen = 0;
    int  ops_seen = 0;
    int  push_seen = 0;
    int  rpop_seen = 0;
    bit  prev_end = 1'b0;

    mxv_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n        (n),
        .op_empty (op_empty),
        .op_pop   (op_pop),
        .lane_en  (lane_en),
        .acc_clr  (acc_clr),
        .row_base (row_base),
        .res_full (res_full),
        .res_push (res_push),
        .res_lane (res_lane),
        .res_pop  (res_pop),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({op_pop, lane_en, acc_clr, row_base, res_push, res_lane,
                     res_pop, tx_valid, busy, done, err});
    endfunction

    task automatic push_ev(input int kind, input int data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic match_ev(input string tag, input int kind, input int data);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_unexpected"}, kind, 0);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_kind"}, kind, e.kind);
            check_eq({tag, "_data"}, data, e.data);
        end
    endtask

    task automatic monitor();
        if (prev_end) check_eq("busy_after_end", int'(busy), 0);
        prev_end = done || err;
        if (err) check_eq("busy_in_err", int'(busy), 1);
        if (!tx_ready) check_eq("tx_hold", int'(tx_valid), 1);
        if (op_pop) begin
            pops_seen++;
            match_ev("op_pop", K_POP, 0);
        end
        if (lane_en != '0) begin
            ops_seen++;
            match_ev("op", K_OP, (int'(acc_clr) << 16) | (int'(row_base) << 8) | int'(lane_en));
        end
        if (res_push) begin
            push_seen++;
            match_ev("res_push", K_PUSH, (int'(row_base) << 8) | int'(res_lane));
        end
        if (res_pop) begin
            rpop_seen++;
            match_ev("res_pop", K_RPOP, 0);
        end
        if (tx_valid && tx_ready) match_ev("tx", K_TX, 0);
        if (done) match_ev("done", K_DONE, ncyc);
        if (err) match_ev("err", K_ERR, ncyc);
    endtask

    // sample mid-cycle, then step to just after the next rising edge
    task automatic tick();
        @(negedge clk);
        ncyc++;
        if (rst) monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic model_job(input int nv, input int t0, input int extra);
        int passes, rb, act;
        if (nv == 0 || nv > MAX_N_DEF) begin
            push_ev(K_ERR, t0 + 2);
        end else begin
            passes = (nv + LANES - 1) / LANES;
            for (int p = 0; p < passes; p++) begin
                rb  = p * LANES;
                act = (nv - rb < LANES) ? nv - rb : LANES;
                for (int c = 0; c < nv; c++) begin
                    push_ev(K_POP, 0);
                    push_ev(K_OP, ((c == 0 ? 1 : 0) << 16) | (rb << 8) | ((1 << act) - 1));
                end
                for (int l = 0; l < act; l++) push_ev(K_PUSH, (rb << 8) | l);
            end
            for (int t = 0; t < nv; t++) begin
                push_ev(K_RPOP, 0);
                push_ev(K_TX, 0);
            end
            push_ev(K_DONE, t0 + 1 + 2 * nv * passes + 3 * nv + 1 + extra);
        end
    endtask

    task automatic run_job(input int nv, input bit st_op, input bit st_res,
                           input bit st_tx, input bit poke);
        int t0, ops_b, push_b, rpop_b, op_left, res_left, tx_left, budget;
        bit poked;
        ops_b    = ops_seen;
        push_b   = push_seen;
        rpop_b   = rpop_seen;
        op_left  = st_op ? 3 : 0;
        res_left = st_res ? 2 : 0;
        tx_left  = st_tx ? 5 : 0;
        poked    = 1'b0;
        start    = 1'b1;
        n        = cnt_t'(nv);
        t0       = ncyc;
        model_job(nv, t0, op_left + res_left + tx_left);
        tick();
        budget = 0;
        while (exp_q.size() != 0 && budget < 600) begin
            if (poke && !poked && (ops_seen - ops_b) == 1) begin
                start = 1'b1;
                n     = cnt_t'(2);
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            op_empty = (op_left > 0) && ((ops_seen - ops_b) == 2);
            if (op_empty) op_left--;
            res_full = (res_left > 0) && ((push_seen - push_b) == 1);
            if (res_full) res_left--;
            tx_ready = !((tx_left > 0) && ((rpop_seen - rpop_b) == 1));
            if (!tx_ready) tx_left--;
            tick();
            budget++;
        end
        start    = 1'b0;
        op_empty = 1'b0;
        res_full = 1'b0;
        tx_ready = 1'b1;
        check_eq("job_events_left", exp_q.size(), 0);
        exp_q.delete();
        tick();
        tick();
    endtask

    task automatic reset_mid_op();
        int ops_b, pops_b, budget;
        ops_b  = ops_seen;
        pops_b = pops_seen;
        push_ev(K_POP, 0);
        push_ev(K_OP, (1 << 16) | 15);
        push_ev(K_POP, 0);
        push_ev(K_OP, 15);
        push_ev(K_POP, 0);
        start = 1'b1;
        n     = cnt_t'(4);
        tick();
        start  = 1'b0;
        budget = 0;
        while (!((pops_seen - pops_b) == 3 && (ops_seen - ops_b) == 2) && budget < 100) begin
            tick();
            budget++;
        end
        check_eq("rst_prefix_events_left", exp_q.size(), 0);
        exp_q.delete();
        rst = 1'b0;
        #1;
        check_eq("rst_outputs_same_cycle", all_outs(), 0);
        repeat (3) tick();
        check_eq("rst_outputs_held", all_outs(), 0);
        rst = 1'b1;
        tick();
        check_eq("rst_idle_after_release", int'(busy), 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        check_eq("reset_outputs", all_outs(), 0);
        rst = 1'b1;
        tick();
        check_eq("idle_after_reset", all_outs(), 0);
        run_job(4, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(6, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(9, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(4, 1'b1, 1'b1, 1'b0, 1'b0);
        run_job(6, 1'b1, 1'b1, 1'b0, 1'b0);
        run_job(4, 1'b0, 1'b0, 1'b1, 1'b1);
        run_job(8, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(5, 1'b1, 1'b1, 1'b1, 1'b0);
        reset_mid_op();
        run_job(3, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
